// File: rtl/branch_stack.sv
// Branch checkpoint stack: one recovery snapshot per in-flight branch,
// with combinational squash and zero-latency restore on mispredict.
module branch_stack #(
  parameter  int B_MASK_WIDTH  = 4,
  parameter  int ROB_SZ_BITS   = 5,
  parameter  int PHYS_REG_SZ   = 64,
  parameter  int ARCH_REG_SZ   = 32,
  parameter  int PHYS_IDX_BITS = 6,
  parameter  int ADDR_BITS     = 32,
  localparam int ENTRY_W       = ADDR_BITS + ROB_SZ_BITS + PHYS_REG_SZ
                               + ARCH_REG_SZ * PHYS_IDX_BITS + B_MASK_WIDTH
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [B_MASK_WIDTH-1:0] b_mm_resolve,
  input  logic                    b_mm_mispred,
  input  logic [B_MASK_WIDTH-1:0][ENTRY_W-1:0] branch_stack_entries,
  input  logic [B_MASK_WIDTH-1:0] next_b_mask,
  output logic [B_MASK_WIDTH-1:0] b_mask_combinational,
  output logic                    restore_valid,
  output logic [ADDR_BITS-1:0]    PC_restore,
  output logic [ROB_SZ_BITS-1:0]  rob_tail_restore,
  output logic [PHYS_REG_SZ-1:0]  free_list_restore,
  output logic [ARCH_REG_SZ-1:0][PHYS_IDX_BITS-1:0] map_table_restore,
  output logic [1:0][B_MASK_WIDTH-1:0][ENTRY_W-1:0] bs_debug
);

  typedef struct packed {
    logic [ADDR_BITS-1:0]   pc;
    logic [ROB_SZ_BITS-1:0] rob_tail;
    logic [PHYS_REG_SZ-1:0] free_list;
    logic [ARCH_REG_SZ-1:0][PHYS_IDX_BITS-1:0] map_table;
    logic [B_MASK_WIDTH-1:0] b_m;
  } entry_t;

  entry_t [B_MASK_WIDTH-1:0] stack_q;
  entry_t [B_MASK_WIDTH-1:0] stack_d;
  entry_t [B_MASK_WIDTH-1:0] entries;
  logic   [B_MASK_WIDTH-1:0] b_mask_q;
  logic   [B_MASK_WIDTH-1:0] squash;
  logic   [B_MASK_WIDTH-1:0] alloc;
  logic                      hit;
  logic                      restore;

  assign entries = branch_stack_entries;

  always_comb begin
    hit               = |(b_mm_resolve & b_mask_q);
    restore           = b_mm_mispred & hit;
    squash            = b_mm_resolve;
    PC_restore        = '0;
    rob_tail_restore  = '0;
    free_list_restore = '0;
    map_table_restore = '0;
    for (int j = 0; j < B_MASK_WIDTH; j++) begin
      // younger branches that depend on the mispredicted one die with it
      if (restore && b_mask_q[j] && |(stack_q[j].b_m & b_mm_resolve))
        squash[j] = 1'b1;
      if (restore && b_mm_resolve[j]) begin
        PC_restore        = PC_restore | stack_q[j].pc;
        rob_tail_restore  = rob_tail_restore | stack_q[j].rob_tail;
        free_list_restore = free_list_restore | stack_q[j].free_list;
        map_table_restore = map_table_restore | stack_q[j].map_table;
      end
    end
  end

  assign restore_valid        = restore;
  assign b_mask_combinational = b_mask_q & ~squash;
  assign alloc                = next_b_mask & ~b_mask_combinational;

  always_comb begin
    stack_d = stack_q;
    for (int i = 0; i < B_MASK_WIDTH; i++) begin
      if (squash[i])
        stack_d[i] = '0;
      else if (alloc[i])
        stack_d[i] = entries[i];
      stack_d[i].b_m = stack_d[i].b_m & ~b_mm_resolve;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_mask_q <= '0;
      stack_q  <= '0;
    end else begin
      b_mask_q <= next_b_mask;
      stack_q  <= stack_d;
    end
  end

  assign bs_debug[1] = stack_q;
  assign bs_debug[0] = stack_d;

endmodule

// File: tb/tb_branch_stack.sv
// Directed scoreboard bench for branch_stack: driver queues expected
// responses, monitor compares them on the falling edge.
module tb_branch_stack;

  typedef struct packed {
    logic [31:0]  pc;
    logic [4:0]   rob;
    logic [63:0]  fl;
    logic [191:0] mt;
    logic [3:0]   bm;
  } ent_t;

  typedef struct {
    string      name;
    logic [3:0] bmc;
    logic       rv;
    ent_t       src;
    ent_t [3:0] stk;
    ent_t [3:0] nxt;
  } exp_t;

  logic                   clock;
  logic                   reset;
  logic [3:0]             b_mm_resolve;
  logic                   b_mm_mispred;
  ent_t [3:0]             ents;
  logic [3:0]             next_b_mask;
  logic [3:0]             bmc;
  logic                   rv;
  logic [31:0]            pc_r;
  logic [4:0]             rob_r;
  logic [63:0]            fl_r;
  logic [31:0][5:0]       mt_r;
  logic [1:0][3:0][296:0] dbg;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  branch_stack dut (
    .clock                (clock),
    .reset                (reset),
    .b_mm_resolve         (b_mm_resolve),
    .b_mm_mispred         (b_mm_mispred),
    .branch_stack_entries (ents),
    .next_b_mask          (next_b_mask),
    .b_mask_combinational (bmc),
    .restore_valid        (rv),
    .PC_restore           (pc_r),
    .rob_tail_restore     (rob_r),
    .free_list_restore    (fl_r),
    .map_table_restore    (mt_r),
    .bs_debug             (dbg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input string f,
                     input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "b_mask_comb", 512'(bmc), 512'(e.bmc));
      chk(e.name, "restore_valid", 512'(rv), 512'(e.rv));
      chk(e.name, "PC_restore", 512'(pc_r), 512'(e.src.pc));
      chk(e.name, "rob_tail", 512'(rob_r), 512'(e.src.rob));
      chk(e.name, "free_list", 512'(fl_r), 512'(e.src.fl));
      chk(e.name, "map_table", 512'(mt_r), 512'(e.src.mt));
      for (int i = 0; i < 4; i++) begin
        chk(e.name, $sformatf("stack%0d", i), 512'(dbg[1][i]), 512'(e.stk[i]));
        chk(e.name, $sformatf("next%0d", i), 512'(dbg[0][i]), 512'(e.nxt[i]));
      end
    end
  end

  function automatic ent_t rnd(input logic [3:0] bm);
    logic [319:0] r;
    ent_t e;
    for (int k = 0; k < 10; k++) r[k*32 +: 32] = $urandom;
    e = ent_t'(r[296:0]);
    e.bm = bm;
    return e;
  endfunction

  function automatic ent_t [3:0] junk();
    ent_t [3:0] j;
    for (int k = 0; k < 4; k++) j[k] = rnd(4'($urandom));
    return j;
  endfunction

  task automatic drive(input logic [3:0] res, input logic mis,
                       input logic [3:0] nbm, input ent_t [3:0] e);
    @(posedge clock);
    #1;
    b_mm_resolve = res;
    b_mm_mispred = mis;
    next_b_mask  = nbm;
    ents         = e;
  endtask

  task automatic expect_out(input string nm, input logic [3:0] b,
                            input logic v, input ent_t src,
                            input ent_t [3:0] stk, input ent_t [3:0] nxt);
    exp_t e;
    e.name = nm;
    e.bmc  = b;
    e.rv   = v;
    e.src  = src;
    e.stk  = stk;
    e.nxt  = nxt;
    q.push_back(e);
  endtask

  ent_t [3:0] z, E, J, S3, S4, S5, S6;
  ent_t       nn, mm, zs;

  initial begin
    z  = '0;
    zs = '0;
    reset        = 1'b0;
    b_mm_resolve = '0;
    b_mm_mispred = 1'b0;
    next_b_mask  = '0;
    ents         = '0;

    E[0] = rnd(4'b0000);
    E[1] = rnd(4'b0001);
    E[2] = rnd(4'b0011);
    E[3] = rnd(4'b0110);
    nn   = rnd(4'b0001);
    mm   = rnd(4'b0001);

    // Reset held for two cycles
    drive(4'b0000, 1'b0, 4'b0000, z);
    expect_out("reset_a", 4'b0000, 1'b0, zs, z, z);
    drive(4'b0000, 1'b0, 4'b0000, z);
    expect_out("reset_b", 4'b0000, 1'b0, zs, z, z);

    // Fill all four slots
    drive(4'b0000, 1'b0, 4'b1111, E);
    reset = 1'b1;
    expect_out("load", 4'b0000, 1'b0, zs, z, E);

    // Correct resolve of slot 2 on a full stack
    S3 = E;
    S3[2] = '0;
    S3[3].bm = 4'b0010;
    drive(4'b0100, 1'b0, 4'b1011, E);
    expect_out("resolve2", 4'b1011, 1'b0, zs, E, S3);

    // Refill slot 2 only; other slots carry junk that must be ignored
    J = junk();
    J[2] = nn;
    S4 = S3;
    S4[2] = nn;
    drive(4'b0000, 1'b0, 4'b1111, J);
    expect_out("refill", 4'b1011, 1'b0, zs, S3, S4);

    // Mispredict slot 1: slot 3 depends on it; full stack takes no writes
    S5 = S4;
    S5[1] = '0;
    S5[3] = '0;
    drive(4'b0010, 1'b1, 4'b0101, junk());
    expect_out("mispred1", 4'b0101, 1'b1, E[1], S4, S5);

    // Mispredict flag with no resolve; slot 1 reallocated
    J = junk();
    J[1] = mm;
    S6 = S5;
    S6[1] = mm;
    drive(4'b0000, 1'b1, 4'b0111, J);
    expect_out("mis_nores", 4'b0101, 1'b0, zs, S5, S6);

    // Resolve on an unoccupied slot
    drive(4'b1000, 1'b1, 4'b0111, junk());
    expect_out("empty_res", 4'b0111, 1'b0, zs, S6, S6);

    // Mispredict the oldest branch: everything dependent is squashed
    drive(4'b0001, 1'b1, 4'b0000, junk());
    expect_out("mispred0", 4'b0000, 1'b1, E[0], S6, z);

    drive(4'b0000, 1'b0, 4'b0000, z);
    expect_out("idle", 4'b0000, 1'b0, zs, z, z);

    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
